// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: parallel-to-serial front end for the pattern-detector FSMs.
// Latency: first bit on bit_out the cycle after the din handshake; 1 bit per clk.
// Backpressure: din_ready = !hb_v; sr + one-word holding buffer keeps back-to-back words gap-free.
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous, active-high
//   din        parallel word, sampled only on din_valid && din_ready
//   din_valid  upstream has a word
//   din_ready  a word can be accepted this cycle
//   bit_out    serial bit (IDLE_BIT when bit_valid is low)
//   bit_valid  bit_out carries payload
//   word_done  last bit of a word is on bit_out
//   busy       shift register or holding buffer occupied
module serial_bit_feeder #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MSB_FIRST = 1,
    parameter logic        IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hb_q, hb_d;
    logic             hb_v_q, hb_v_d;

    logic             active;
    logic             acc;
    logic             last;
    logic [WIDTH-1:0] sr_shifted;

    // Outputs decode registers only, so there is no din_valid -> output path.
    assign active    = (state_q == SHIFT);
    assign din_ready = !hb_v_q;
    assign bit_valid = active;
    assign bit_out   = active ? ((MSB_FIRST != 0) ? sr_q[WIDTH-1] : sr_q[0]) : IDLE_BIT;
    assign word_done = active && (cnt_q == CW'(WIDTH - 1));
    assign busy      = active || hb_v_q;

    assign acc  = din_valid && din_ready;
    assign last = word_done;

    // Move the next bit to the output end; vacated end fills with zero.
    assign sr_shifted = (MSB_FIRST != 0) ? {sr_q[WIDTH-2:0], 1'b0}
                                         : {1'b0, sr_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        hb_d    = hb_q;
        hb_v_d  = hb_v_q;
        case (state_q)
            IDLE: begin
                if (acc) begin
                    sr_d    = din;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!last) begin
                    sr_d  = sr_shifted;
                    cnt_d = cnt_q + 1'b1;
                    if (acc) begin
                        hb_d   = din;
                        hb_v_d = 1'b1;
                    end
                end else if (hb_v_q) begin
                    // Holding buffer drains into sr; din_ready is low this cycle.
                    sr_d   = hb_q;
                    hb_v_d = 1'b0;
                    cnt_d  = '0;
                end else if (acc) begin
                    // Direct bypass into sr keeps the stream gap-free.
                    sr_d  = din;
                    cnt_d = '0;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            hb_q    <= '0;
            hb_v_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            hb_q    <= hb_d;
            hb_v_q  <= hb_v_d;
        end
    end

endmodule
